// File: rtl/uart_pkg.sv
// Purpose: shared types and constants for the UART result-transmit path.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
//
// Contents:
//   BYTE_W           width of one UART payload byte
//   tx_ctrl_state_t  state encoding of the tx_control sequencer
package uart_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    WAIT_HI,
    WAIT_LO,
    DONE
  } tx_ctrl_state_t;

endpackage

// File: rtl/tx_control.sv
// Purpose: latch an N_BYTES result on trigger and send it LSB-first through uart_tx.
// Latency: trigger at edge k -> tx_start registered high after edge k+1 when the line is idle.
// Backpressure: waits on tx_busy, re-issues start after ACK_TIMEOUT cycles without busy, ignores trigger while busy.
//
// Ports:
//   clk       in   system clock
//   reset     in   synchronous, active-high reset
//   trigger   in   1-cycle send request; accepted only while idle
//   result    in   value to transmit, sampled on the accepting edge only
//   tx_busy   in   uart_tx busy (high while a frame is on the line)
//   tx_start  out  1-cycle start request to uart_tx
//   tx_data   out  byte presented to uart_tx; held until the next start or reset
//   busy      out  high whenever the sequencer is not idle
//   done      out  1-cycle pulse once the last byte has left the line
module tx_control
  import uart_pkg::*;
#(
  parameter int N_BYTES     = 2,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      trigger,
  input  logic [BYTE_W*N_BYTES-1:0] result,
  input  logic                      tx_busy,
  output logic                      tx_start,
  output logic [BYTE_W-1:0]         tx_data,
  output logic                      busy,
  output logic                      done
);

  localparam int IDX_W = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
  localparam int TMO_W = $clog2(ACK_TIMEOUT) + 1;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_BYTES - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TIMEOUT - 1);

  tx_ctrl_state_t            state, state_nxt;
  logic [IDX_W-1:0]          byte_idx, byte_idx_nxt;
  logic [BYTE_W*N_BYTES-1:0] shadow, shadow_nxt;
  logic [TMO_W-1:0]          tmo, tmo_nxt;

  logic              tx_start_nxt;
  logic [BYTE_W-1:0] tx_data_nxt;
  logic              busy_nxt;
  logic              done_nxt;

  always_comb begin
    state_nxt    = state;
    byte_idx_nxt = byte_idx;
    shadow_nxt   = shadow;
    tmo_nxt      = tmo;
    tx_start_nxt = 1'b0;
    tx_data_nxt  = tx_data;
    done_nxt     = 1'b0;

    case (state)
      IDLE: begin
        if (trigger) begin
          // Only the shadow copy is transmitted; result may move on freely.
          shadow_nxt   = result;
          byte_idx_nxt = '0;
          state_nxt    = SEND;
        end
      end

      SEND: begin
        // A frame still on the line (ours or someone else's) holds us here.
        if (!tx_busy) begin
          tx_start_nxt = 1'b1;
          tx_data_nxt  = shadow[int'(byte_idx) * BYTE_W +: BYTE_W];
          tmo_nxt      = '0;
          state_nxt    = WAIT_HI;
        end
      end

      WAIT_HI: begin
        if (tx_busy) begin
          state_nxt = WAIT_LO;
        end else begin
          tmo_nxt = tmo + TMO_W'(1);
          // No acknowledge: go back and present the same byte again.
          // Returning through SEND clears tmo, so it can never wrap.
          if (tmo == TMO_LAST) begin
            state_nxt = SEND;
          end
        end
      end

      WAIT_LO: begin
        if (!tx_busy) begin
          if (byte_idx == LAST_IDX) begin
            state_nxt = DONE;
            done_nxt  = 1'b1;
          end else begin
            byte_idx_nxt = byte_idx + IDX_W'(1);
            state_nxt    = SEND;
          end
        end
      end

      DONE: begin
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase

    // Registered from next state so busy tracks the state register exactly.
    busy_nxt = (state_nxt != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      byte_idx <= '0;
      shadow   <= '0;
      tmo      <= '0;
      tx_start <= 1'b0;
      tx_data  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      byte_idx <= byte_idx_nxt;
      shadow   <= shadow_nxt;
      tmo      <= tmo_nxt;
      tx_start <= tx_start_nxt;
      tx_data  <= tx_data_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
    end
  end

endmodule

// File: tb/tb_tx_control.sv
// Purpose: self-checking bench for tx_control with a uart_tx line model and transfer-level reference.
// Latency: n/a (testbench).
// Backpressure: the line model drives tx_busy; it can be stalled or forced busy.
module tb_tx_control;

  localparam int N_BYTES     = 2;
  localparam int ACK_TIMEOUT = 16;
  localparam int RES_W       = 8 * N_BYTES;

  logic             clk     = 1'b0;
  logic             reset   = 1'b1;
  logic             trigger = 1'b0;
  logic             tx_busy = 1'b0;
  logic [RES_W-1:0] result  = '0;
  logic             tx_start;
  logic [7:0]       tx_data;
  logic             busy;
  logic             done;

  tx_control #(.N_BYTES(N_BYTES), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
    .clk      (clk),
    .reset    (reset),
    .trigger  (trigger),
    .result   (result),
    .tx_busy  (tx_busy),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // uart_tx line model
  int         frame_len  = 10;
  bit         uart_resp  = 1'b1;
  bit         force_busy = 1'b0;
  bit         rise_next  = 1'b0;
  bit         line_busy  = 1'b0;
  int         line_left  = 0;
  logic [7:0] sent_q[$];
  int         starts_q[$];
  int         start_cnt  = 0;
  int         done_cnt   = 0;
  int         last_fall  = 0;
  int         last_done  = 0;

  // transfer-level reference
  bit         ref_active   = 1'b0;
  logic [7:0] exp_q[$];
  bit         want_send    = 1'b0;
  int         want_from    = 0;
  int         exp_start    = -10;
  int         exp_done     = -10;
  bit         await_ack    = 1'b0;
  int         ack_deadline = 0;
  logic [7:0] exp_tx_data  = 8'h00;

  int               t0, g0, d0, n0, k_wait;
  logic [RES_W-1:0] val;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, expv);
    end
  endtask

  // One clock cycle: compare outputs, advance the line model, apply the reference rules.
  task automatic step();
    bit fell;
    @(negedge clk);
    cyc++;
    trigger = 1'b0;
    if (cyc == exp_done + 1) ref_active = 1'b0;
    if (cyc == exp_start) begin
      if (exp_q.size() > 0) exp_tx_data = exp_q[0];
      await_ack    = 1'b1;
      ack_deadline = cyc + ACK_TIMEOUT - 1;
    end

    check("tx_start", tx_start, cyc == exp_start);
    check("done", done, cyc == exp_done);
    check("busy", busy, ref_active);
    check("tx_data", tx_data, exp_tx_data);
    if (tx_start === 1'b1) begin start_cnt++; starts_q.push_back(cyc); end
    if (done === 1'b1) begin done_cnt++; last_done = cyc; end

    fell = 1'b0;
    if (rise_next) begin
      line_busy = 1'b1;
      line_left = frame_len;
      rise_next = 1'b0;
    end else if (line_busy) begin
      line_left--;
      if (line_left == 0) begin
        line_busy = 1'b0;
        fell      = 1'b1;
        last_fall = cyc;
      end
    end
    if (tx_start === 1'b1 && uart_resp && !line_busy && !force_busy) begin
      rise_next = 1'b1;
      sent_q.push_back(tx_data);
      check("byte_pending", (ref_active && exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        check("byte", tx_data, exp_q[0]);
        void'(exp_q.pop_front());
      end
    end
    tx_busy = line_busy | force_busy;

    if (fell && ref_active) begin
      if (exp_q.size() == 0) exp_done = cyc + 1;
      else begin want_send = 1'b1; want_from = cyc + 1; end
    end
    if (await_ack) begin
      if (tx_busy === 1'b1) await_ack = 1'b0;
      else if (cyc == ack_deadline) begin
        await_ack = 1'b0;
        want_send = 1'b1;
        want_from = cyc + 1;
      end
    end
    if (want_send && cyc >= want_from && tx_busy === 1'b0) begin
      exp_start = cyc + 1;
      want_send = 1'b0;
    end
  endtask

  // Drive a trigger for the current cycle; accepted only when no transfer is in progress.
  task automatic fire(input logic [RES_W-1:0] v);
    trigger = 1'b1;
    result  = v;
    if (!ref_active) begin
      ref_active = 1'b1;
      exp_q.delete();
      for (int i = 0; i < N_BYTES; i++) exp_q.push_back(v[8*i +: 8]);
      want_send = 1'b1;
      want_from = cyc + 1;
    end
  endtask

  task automatic apply_reset(input int n);
    reset = 1'b1;
    ref_active = 1'b0;
    exp_q.delete();
    want_send   = 1'b0;
    await_ack   = 1'b0;
    exp_start   = -10;
    exp_done    = -10;
    exp_tx_data = 8'h00;
    repeat (n) step();
    reset = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n;
    n = 0;
    while ((ref_active || line_busy || rise_next) && n < budget) begin
      step();
      n++;
    end
    check({tag, "_budget"}, (n < budget), 1);
  endtask

  task automatic wait_line_busy(input string tag, input int budget);
    int n;
    n = 0;
    while (!line_busy && n < budget) begin
      step();
      n++;
    end
    check({tag, "_line_busy"}, line_busy, 1);
  endtask

  initial begin
    // reset state
    apply_reset(3);
    check("rst_tx_start", tx_start, 0);
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    repeat (2) step();

    // basic transfer
    frame_len = 10;
    sent_q.delete(); starts_q.delete(); d0 = done_cnt;
    fire(16'hBEEF); t0 = cyc;
    wait_idle("t2", 200);
    check("t2_nbytes", sent_q.size(), 2);
    check("t2_b0", sent_q[0], 8'hEF);
    check("t2_b1", sent_q[1], 8'hBE);
    check("t2_nstart", starts_q.size(), 2);
    check("t2_latency", starts_q[0] - t0, 2);
    check("t2_done_gap", last_done - last_fall, 1);
    check("t2_ndone", done_cnt - d0, 1);
    check("t2_busy_after", busy, 0);
    check("t2_data_hold", tx_data, 8'hBE);
    repeat (3) step();

    // shadowing: result changes right after the accepting edge
    sent_q.delete(); d0 = done_cnt;
    fire(16'h1234);
    step();
    result = 16'hFFFF;
    wait_idle("t3", 200);
    check("t3_b0", sent_q[0], 8'h34);
    check("t3_b1", sent_q[1], 8'h12);
    check("t3_ndone", done_cnt - d0, 1);
    step();

    // trigger during a frame is ignored
    sent_q.delete(); d0 = done_cnt;
    fire(16'h9A3C);
    wait_line_busy("t4", 50);
    repeat (2) step();
    fire(16'h5555);
    step();
    wait_idle("t4", 200);
    check("t4_nbytes", sent_q.size(), 2);
    check("t4_b0", sent_q[0], 8'h3C);
    check("t4_b1", sent_q[1], 8'h9A);
    check("t4_ndone", done_cnt - d0, 1);
    step();

    // reset in the middle of a frame
    d0 = done_cnt;
    fire(16'hC0DE);
    wait_line_busy("t1", 50);
    repeat (3) step();
    apply_reset(3);
    check("t1_tx_start", tx_start, 0);
    check("t1_tx_data", tx_data, 8'h00);
    check("t1_busy", busy, 0);
    check("t1_done", done, 0);
    wait_idle("t1", 100);
    repeat (5) step();
    check("t1_ndone", done_cnt - d0, 0);

    // acknowledge timeout: line ignores starts for 40 cycles
    sent_q.delete(); starts_q.delete(); d0 = done_cnt;
    uart_resp = 1'b0;
    fire(16'h7E81); t0 = cyc;
    n0 = start_cnt;
    repeat (40) step();
    check("t5_retries", start_cnt - n0, (40 - 2) / (ACK_TIMEOUT + 1) + 1);
    check("t5_first", starts_q[0] - t0, 2);
    check("t5_period0", starts_q[1] - starts_q[0], ACK_TIMEOUT + 1);
    check("t5_period1", starts_q[2] - starts_q[1], ACK_TIMEOUT + 1);
    check("t5_retry_data", tx_data, 8'h81);
    uart_resp = 1'b1;
    wait_idle("t5", 400);
    check("t5_b0", sent_q[0], 8'h81);
    check("t5_b1", sent_q[1], 8'h7E);
    check("t5_ndone", done_cnt - d0, 1);
    step();

    // line already busy when the trigger is accepted
    sent_q.delete(); starts_q.delete(); d0 = done_cnt;
    force_busy = 1'b1;
    step();
    fire(16'h4D2B);
    n0 = start_cnt;
    repeat (6) step();
    check("t6_held", start_cnt - n0, 0);
    force_busy = 1'b0;
    step(); g0 = cyc;
    wait_idle("t6", 200);
    check("t6_first", starts_q[0] - g0, 1);
    check("t6_b0", sent_q[0], 8'h2B);
    check("t6_b1", sent_q[1], 8'h4D);
    check("t6_ndone", done_cnt - d0, 1);

    // randomized transfers with stray triggers while busy
    for (int k = 0; k < 25; k++) begin
      frame_len = $urandom_range(2, 12);
      repeat ($urandom_range(0, 3)) step();
      val = RES_W'($urandom);
      sent_q.delete(); d0 = done_cnt;
      fire(val);
      k_wait = 0;
      while ((ref_active || line_busy || rise_next) && k_wait < 300) begin
        step();
        k_wait++;
        if (ref_active && $urandom_range(0, 7) == 0) fire(RES_W'($urandom));
      end
      check("rnd_budget", (k_wait < 300), 1);
      check("rnd_nbytes", sent_q.size(), N_BYTES);
      for (int i = 0; i < N_BYTES && i < sent_q.size(); i++)
        check("rnd_byte", sent_q[i], val[8*i +: 8]);
      check("rnd_ndone", done_cnt - d0, 1);
    end
    repeat (3) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
